// File: rtl/ft_async_pkg.sv
// Shared types, default cycle timings and helpers for the FT2232H async FIFO scheduler.
package ft_async_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RD_STROBE = 3'd1,
    ST_RD_RECOV  = 3'd2,
    ST_WR_SETUP  = 3'd3,
    ST_WR_STROBE = 3'd4,
    ST_WR_HOLD   = 3'd5,
    ST_WR_RECOV  = 3'd6
  } state_e;

  // Nanoseconds to clock cycles, rounded up so a timing minimum is never undercut.
  function automatic int unsigned ns2cyc(input int unsigned freq_mhz, input int unsigned ns);
    return (freq_mhz * ns + 32'd999) / 32'd1000;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned CLK_MHZ         = 32'd200;
  localparam int unsigned RD_SAMPLE_CYC_D = ns2cyc(CLK_MHZ, 32'd15);
  localparam int unsigned RD_PULSE_CYC_D  = ns2cyc(CLK_MHZ, 32'd30);
  localparam int unsigned WR_SETUP_CYC_D  = ns2cyc(CLK_MHZ, 32'd5);
  localparam int unsigned WR_PULSE_CYC_D  = ns2cyc(CLK_MHZ, 32'd30);
  localparam int unsigned RECOV_CYC_D     = ns2cyc(CLK_MHZ, 32'd30);

endpackage

// File: rtl/ft_async_sched_if.sv
// uP-side streaming interface of the FT2232H scheduler.
interface ft_async_sched_if #(
  parameter int unsigned DATA_W = 32'd8
);
  logic              ext_wr;
  logic [DATA_W-1:0] ext_wr_data;
  logic              ext_wr_ack;
  logic              ext_rd;
  logic              ext_rd_data_valid;
  logic [DATA_W-1:0] ext_rd_data;
  logic              busy;

  modport master (
    output ext_wr, ext_wr_data, ext_rd,
    input  ext_wr_ack, ext_rd_data_valid, ext_rd_data, busy
  );

  modport slave (
    input  ext_wr, ext_wr_data, ext_rd,
    output ext_wr_ack, ext_rd_data_valid, ext_rd_data, busy
  );
endinterface

// File: rtl/ft_sync2.sv
// Two-flop synchronizer for the FT2232H status pins; idles high (not ready).
module ft_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  logic r_sync;

  // Metastability chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;
endmodule

// File: rtl/ft_async_sched.sv
// Arbiter/sequencer for the FT2232H async 245-FIFO bus. One FSM with a shared
// down-counter times every strobe phase; all pin-facing outputs are registered.
module ft_async_sched
  import ft_async_pkg::*;
#(
  parameter int unsigned DATA_W        = 32'd8,
  parameter int unsigned RD_SAMPLE_CYC = RD_SAMPLE_CYC_D,
  parameter int unsigned RD_PULSE_CYC  = RD_PULSE_CYC_D,
  parameter int unsigned WR_SETUP_CYC  = WR_SETUP_CYC_D,
  parameter int unsigned WR_PULSE_CYC  = WR_PULSE_CYC_D,
  parameter int unsigned RECOV_CYC     = RECOV_CYC_D
) (
  input  logic              clk,
  input  logic              rst,
  ft_async_sched_if.slave   up,
  input  logic              RXF_N,
  input  logic              TXE_N,
  output logic              RD_N,
  output logic              WR_N,
  inout  wire  [DATA_W-1:0] DATA
);

  localparam int unsigned MAX_CYC = max_u(max_u(max_u(RD_SAMPLE_CYC, RD_PULSE_CYC),
                                                max_u(WR_SETUP_CYC, WR_PULSE_CYC)), RECOV_CYC);
  localparam int unsigned CW = $clog2(MAX_CYC) + 32'd1;
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t LD_RD_PULSE = cnt_t'(RD_PULSE_CYC - 32'd1);
  localparam cnt_t LD_WR_SETUP = cnt_t'(WR_SETUP_CYC - 32'd1);
  localparam cnt_t LD_WR_PULSE = cnt_t'(WR_PULSE_CYC - 32'd1);
  localparam cnt_t LD_RECOV    = cnt_t'(RECOV_CYC - 32'd1);
  localparam cnt_t RD_CAP_AT   = cnt_t'(RD_PULSE_CYC - RD_SAMPLE_CYC);
  localparam cnt_t CNT_ZERO    = cnt_t'(1'b0);

  if (RD_SAMPLE_CYC == 32'd0 || RD_PULSE_CYC == 32'd0 || WR_SETUP_CYC == 32'd0 ||
      WR_PULSE_CYC == 32'd0 || RECOV_CYC == 32'd0) begin : g_bad_zero_cyc
    $error("ft_async_sched: cycle parameters must be non-zero");
  end
  if (RD_SAMPLE_CYC > RD_PULSE_CYC) begin : g_bad_sample
    $error("ft_async_sched: RD_SAMPLE_CYC must not exceed RD_PULSE_CYC");
  end

  state_e            r_state;
  state_e            w_state_nxt;
  cnt_t              r_cnt;
  cnt_t              w_cnt_nxt;
  cnt_t              w_cnt_dec;
  logic              w_cnt_zero;
  logic              w_rxf_s;
  logic              w_txe_s;
  logic              w_rd_req;
  logic              w_wr_req;
  logic              w_grant_rd;
  logic              w_grant_wr;
  logic              w_capture;
  logic              r_last_wr;
  logic              r_rd_n;
  logic              r_wr_n;
  logic              r_oe;
  logic              r_busy;
  logic              r_wr_ack;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;
  logic [DATA_W-1:0] r_wdata;

  ft_sync2 u_sync_rxf (.clk(clk), .rst(rst), .i_d(RXF_N), .o_q(w_rxf_s));
  ft_sync2 u_sync_txe (.clk(clk), .rst(rst), .i_d(TXE_N), .o_q(w_txe_s));

  assign w_rd_req   = ~w_rxf_s & up.ext_rd;
  assign w_wr_req   = ~w_txe_s & up.ext_wr;
  assign w_cnt_dec  = r_cnt - cnt_t'(1'b1);
  assign w_cnt_zero = (r_cnt == CNT_ZERO);

  // State and phase counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= CNT_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state; the counter is reloaded on every state entry and exits at zero.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_cnt_dec;
    w_grant_rd  = 1'b0;
    w_grant_wr  = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = CNT_ZERO;
        // Tie goes to read whenever the previous grant was a write.
        if (w_rd_req && (!w_wr_req || r_last_wr)) begin
          w_grant_rd  = 1'b1;
          w_state_nxt = ST_RD_STROBE;
          w_cnt_nxt   = LD_RD_PULSE;
        end else if (w_wr_req) begin
          w_grant_wr  = 1'b1;
          w_state_nxt = ST_WR_SETUP;
          w_cnt_nxt   = LD_WR_SETUP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RD_STROBE: begin
        w_capture = (r_cnt == RD_CAP_AT);
        if (w_cnt_zero) begin
          w_state_nxt = ST_RD_RECOV;
          w_cnt_nxt   = LD_RECOV;
        end else begin
          w_state_nxt = ST_RD_STROBE;
        end
      end
      ST_WR_SETUP: begin
        if (w_cnt_zero) begin
          w_state_nxt = ST_WR_STROBE;
          w_cnt_nxt   = LD_WR_PULSE;
        end else begin
          w_state_nxt = ST_WR_SETUP;
        end
      end
      ST_WR_STROBE: begin
        if (w_cnt_zero) begin
          w_state_nxt = ST_WR_HOLD;
          w_cnt_nxt   = CNT_ZERO;
        end else begin
          w_state_nxt = ST_WR_STROBE;
        end
      end
      ST_WR_HOLD: begin
        w_state_nxt = ST_WR_RECOV;
        w_cnt_nxt   = LD_RECOV;
      end
      ST_RD_RECOV, ST_WR_RECOV: begin
        if (w_cnt_zero) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = CNT_ZERO;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

  // Outputs decoded from the next state so pins change cleanly on the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_n     <= 1'b1;
      r_wr_n     <= 1'b1;
      r_oe       <= 1'b0;
      r_busy     <= 1'b0;
      r_wr_ack   <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= {DATA_W{1'b0}};
      r_wdata    <= {DATA_W{1'b0}};
      r_last_wr  <= 1'b1;
    end else begin
      r_rd_n     <= (w_state_nxt != ST_RD_STROBE);
      r_wr_n     <= (w_state_nxt != ST_WR_STROBE);
      r_oe       <= (w_state_nxt == ST_WR_SETUP) || (w_state_nxt == ST_WR_STROBE) ||
                    (w_state_nxt == ST_WR_HOLD);
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_wr_ack   <= w_grant_wr;
      r_rd_valid <= w_capture;
      if (w_capture) begin
        r_rd_data <= DATA;
      end
      if (w_grant_wr) begin
        r_wdata <= up.ext_wr_data;
      end
      if (w_grant_rd || w_grant_wr) begin
        r_last_wr <= w_grant_wr;
      end
    end
  end

  assign DATA                 = r_oe ? r_wdata : {DATA_W{1'bz}};
  assign RD_N                 = r_rd_n;
  assign WR_N                 = r_wr_n;
  assign up.busy              = r_busy;
  assign up.ext_wr_ack        = r_wr_ack;
  assign up.ext_rd_data_valid = r_rd_valid;
  assign up.ext_rd_data       = r_rd_data;

endmodule

// File: tb/tb_ft_async_sched.sv
// Self-checking bench for ft_async_sched: directed vector table, corner-case
// sequences and a randomized run against a transaction-schedule reference model.
module tb_ft_async_sched;
  localparam int DW   = 8;
  localparam int NCYC = 1500;
  localparam int NSZ  = NCYC + 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          rxf_n;
  logic          txe_n;
  wire           rd_n;
  wire           wr_n;
  wire  [DW-1:0] data_bus;
  logic [DW-1:0] host_byte;

  int n_tests = 0;
  int n_fail  = 0;

  ft_async_sched_if #(.DATA_W(DW)) up_if ();

  ft_async_sched #(.DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .up(up_if),
    .RXF_N(rxf_n), .TXE_N(txe_n), .RD_N(rd_n), .WR_N(wr_n), .DATA(data_bus)
  );

  // Host side of the FT2232H: drives the bus only while RD_N is low.
  assign data_bus = (rd_n == 1'b0) ? host_byte : 8'bzzzzzzzz;

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; rxf_n = 1'b1; txe_n = 1'b1;
    up_if.ext_wr = 1'b0; up_if.ext_rd = 1'b0; up_if.ext_wr_data = 8'h00;
    host_byte = 8'h00;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] din, output int lat, output int width,
                         output int nvalid, output logic [7:0] got);
    host_byte = din; up_if.ext_rd = 1'b1; rxf_n = 1'b0;
    lat = 0; width = 0; nvalid = 0;
    while (rd_n !== 1'b0 && lat < 30) begin tick(); lat++; end
    rxf_n = 1'b1;
    while (rd_n === 1'b0 && width < 30) begin
      if (up_if.ext_rd_data_valid) nvalid++;
      tick(); width++;
    end
    for (int i = 0; i < 20 && up_if.busy; i++) begin
      if (up_if.ext_rd_data_valid) nvalid++;
      tick();
    end
    got = up_if.ext_rd_data;
  endtask

  task automatic do_write(input logic [7:0] din, output int lat, output int width, output int nack,
                          output logic [7:0] setup_d, output logic [7:0] hold_d, output logic setup_wrn);
    txe_n = 1'b0;
    repeat (3) tick();
    up_if.ext_wr_data = din; up_if.ext_wr = 1'b1;
    lat = 0; width = 0; nack = 0;
    while (up_if.ext_wr_ack !== 1'b1 && lat < 30) begin tick(); lat++; end
    if (up_if.ext_wr_ack) nack++;
    up_if.ext_wr = 1'b0; up_if.ext_wr_data = ~din; txe_n = 1'b1;
    setup_d = data_bus; setup_wrn = wr_n;
    tick();
    while (wr_n === 1'b0 && width < 30) begin
      if (up_if.ext_wr_ack) nack++;
      tick(); width++;
    end
    hold_d = data_bus;
    for (int i = 0; i < 20 && up_if.busy; i++) begin
      if (up_if.ext_wr_ack) nack++;
      tick();
    end
  endtask

  typedef struct {
    logic       is_wr;
    logic [7:0] din;
    int         exp_lat;
    int         exp_width;
  } vec_t;

  vec_t vecs [6];

  bit         exp_rd_n  [NSZ];
  bit         exp_wr_n  [NSZ];
  bit         exp_oe    [NSZ];
  bit         exp_ack   [NSZ];
  bit         exp_valid [NSZ];
  bit         exp_busy  [NSZ];
  logic [7:0] exp_rdata [NSZ];
  logic [7:0] exp_wdata [NSZ];
  bit         p_rxf     [NSZ];
  bit         p_txe     [NSZ];

  int         lat, width, nvalid, nack, ovl, nlow, ng, m_free;
  logic [7:0] got, setup_d, hold_d;
  logic       setup_wrn, prev_rd, prev_wr, m_last_wr, s_rxf, s_txe, rreq, wreq;
  int         grants [4];

  initial begin
    vecs[0] = '{1'b0, 8'hA5, 3, 6};
    vecs[1] = '{1'b1, 8'h3C, 1, 6};
    vecs[2] = '{1'b0, 8'h00, 3, 6};
    vecs[3] = '{1'b1, 8'hFF, 1, 6};
    vecs[4] = '{1'b0, 8'h5A, 3, 6};
    vecs[5] = '{1'b1, 8'h81, 1, 6};

    do_reset();
    check("reset RD_N", 32'(rd_n), 32'd1);
    check("reset WR_N", 32'(wr_n), 32'd1);
    check("reset busy", 32'(up_if.busy), 32'd0);
    check("reset ack", 32'(up_if.ext_wr_ack), 32'd0);
    check("reset valid", 32'(up_if.ext_rd_data_valid), 32'd0);
    check("reset rd_data", 32'(up_if.ext_rd_data), 32'd0);
    check("reset oe", 32'(dut.r_oe), 32'd0);

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].is_wr) begin
        do_write(vecs[v].din, lat, width, nack, setup_d, hold_d, setup_wrn);
        check($sformatf("vec%0d wr ack latency", v), 32'(lat), 32'(vecs[v].exp_lat));
        check($sformatf("vec%0d WR_N width", v), 32'(width), 32'(vecs[v].exp_width));
        check($sformatf("vec%0d ack count", v), 32'(nack), 32'd1);
        check($sformatf("vec%0d setup WR_N", v), 32'(setup_wrn), 32'd1);
        check($sformatf("vec%0d setup DATA", v), 32'(setup_d), 32'(vecs[v].din));
        check($sformatf("vec%0d hold DATA", v), 32'(hold_d), 32'(vecs[v].din));
      end else begin
        do_read(vecs[v].din, lat, width, nvalid, got);
        up_if.ext_rd = 1'b0;
        check($sformatf("vec%0d RD_N latency", v), 32'(lat), 32'(vecs[v].exp_lat));
        check($sformatf("vec%0d RD_N width", v), 32'(width), 32'(vecs[v].exp_width));
        check($sformatf("vec%0d valid count", v), 32'(nvalid), 32'd1);
        check($sformatf("vec%0d rd_data", v), 32'(got), 32'(vecs[v].din));
      end
    end

    // Tie: both sides ready continuously; grants must alternate starting with read.
    do_reset();
    rxf_n = 1'b0; txe_n = 1'b0; up_if.ext_rd = 1'b1; up_if.ext_wr = 1'b1;
    up_if.ext_wr_data = 8'h77; host_byte = 8'h11;
    ng = 0; ovl = 0; prev_rd = 1'b1; prev_wr = 1'b1;
    for (int c = 0; c < 70; c++) begin
      tick();
      if (rd_n === 1'b0 && dut.r_oe === 1'b1) ovl++;
      if (rd_n === 1'b0 && wr_n === 1'b0) ovl++;
      if (ng < 4 && prev_rd && !rd_n) begin grants[ng] = 1; ng++; end
      if (ng < 4 && prev_wr && !wr_n) begin grants[ng] = 2; ng++; end
      prev_rd = rd_n; prev_wr = wr_n;
    end
    check("tie grant count", 32'(ng), 32'd4);
    check("tie grant0 R", 32'(grants[0]), 32'd1);
    check("tie grant1 W", 32'(grants[1]), 32'd2);
    check("tie grant2 R", 32'(grants[2]), 32'd1);
    check("tie grant3 W", 32'(grants[3]), 32'd2);
    check("tie overlap", 32'(ovl), 32'd0);

    // Back-pressure: FIFO has data but uP refuses it.
    do_reset();
    rxf_n = 1'b0; up_if.ext_rd = 1'b0; nlow = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (rd_n === 1'b0) nlow++;
    end
    check("bp RD_N held high", 32'(nlow), 32'd0);
    up_if.ext_rd = 1'b1;
    tick();
    check("bp RD_N one cycle after ext_rd", 32'(rd_n), 32'd0);
    rxf_n = 1'b1; up_if.ext_rd = 1'b0;
    for (int i = 0; i < 20 && up_if.busy; i++) tick();

    // Reset in the middle of the write strobe.
    do_reset();
    txe_n = 1'b0;
    repeat (3) tick();
    up_if.ext_wr_data = 8'hC3; up_if.ext_wr = 1'b1;
    for (int i = 0; i < 10 && wr_n !== 1'b0; i++) tick();
    up_if.ext_wr = 1'b0;
    check("rst-mid WR_N low before reset", 32'(wr_n), 32'd0);
    tick(); tick();
    rst = 1'b1;
    tick();
    check("rst-mid WR_N", 32'(wr_n), 32'd1);
    check("rst-mid oe", 32'(dut.r_oe), 32'd0);
    check("rst-mid busy", 32'(up_if.busy), 32'd0);
    check("rst-mid RD_N", 32'(rd_n), 32'd1);
    rst = 1'b0; txe_n = 1'b1; nlow = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (wr_n === 1'b0) nlow++;
    end
    check("rst-mid no resumed strobe", 32'(nlow), 32'd0);

    // Glitch: RXF_N rises during the strobe; the strobe completes and no new read starts.
    do_reset();
    do_read(8'h96, lat, width, nvalid, got);
    check("glitch RD_N width", 32'(width), 32'd6);
    check("glitch rd_data", 32'(got), 32'h96);
    nlow = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (rd_n === 1'b0) nlow++;
    end
    check("glitch no second read", 32'(nlow), 32'd0);
    up_if.ext_rd = 1'b0;

    // Randomized run against a schedule model: each grant books its pin activity ahead.
    do_reset();
    for (int c = 0; c < NSZ; c++) begin
      exp_rd_n[c] = 1'b1; exp_wr_n[c] = 1'b1; exp_oe[c] = 1'b0; exp_ack[c] = 1'b0;
      exp_valid[c] = 1'b0; exp_busy[c] = 1'b0; exp_rdata[c] = 8'h00; exp_wdata[c] = 8'h00;
    end
    m_free = 0; m_last_wr = 1'b1;
    for (int k = 0; k < NCYC; k++) begin
      if (k > 0) tick();
      if ($urandom_range(3) == 0) rxf_n = ~rxf_n;
      if ($urandom_range(3) == 0) txe_n = ~txe_n;
      up_if.ext_rd      = ($urandom_range(9) < 7);
      up_if.ext_wr      = $urandom_range(1) == 1;
      up_if.ext_wr_data = 8'($urandom);
      if (k >= m_free) host_byte = 8'($urandom);
      p_rxf[k] = rxf_n; p_txe[k] = txe_n;
      if (k >= m_free) begin
        s_rxf = (k >= 2) ? p_rxf[k-2] : 1'b1;
        s_txe = (k >= 2) ? p_txe[k-2] : 1'b1;
        rreq  = !s_rxf && up_if.ext_rd;
        wreq  = !s_txe && up_if.ext_wr;
        if (rreq && (!wreq || m_last_wr)) begin
          for (int c = k + 1; c <= k + 6; c++) exp_rd_n[c] = 1'b0;
          for (int c = k + 1; c <= k + 12; c++) exp_busy[c] = 1'b1;
          exp_valid[k+4] = 1'b1;
          for (int c = k + 4; c < NSZ; c++) exp_rdata[c] = host_byte;
          m_free = k + 13; m_last_wr = 1'b0;
        end else if (wreq) begin
          for (int c = k + 1; c <= k + 8; c++) begin
            exp_oe[c] = 1'b1; exp_wdata[c] = up_if.ext_wr_data;
          end
          for (int c = k + 2; c <= k + 7; c++) exp_wr_n[c] = 1'b0;
          for (int c = k + 1; c <= k + 14; c++) exp_busy[c] = 1'b1;
          exp_ack[k+1] = 1'b1;
          m_free = k + 15; m_last_wr = 1'b1;
        end
      end
      #4;
      check($sformatf("rnd RD_N c%0d", k), 32'(rd_n), 32'(exp_rd_n[k]));
      check($sformatf("rnd WR_N c%0d", k), 32'(wr_n), 32'(exp_wr_n[k]));
      check($sformatf("rnd ack c%0d", k), 32'(up_if.ext_wr_ack), 32'(exp_ack[k]));
      check($sformatf("rnd valid c%0d", k), 32'(up_if.ext_rd_data_valid), 32'(exp_valid[k]));
      check($sformatf("rnd rd_data c%0d", k), 32'(up_if.ext_rd_data), 32'(exp_rdata[k]));
      check($sformatf("rnd busy c%0d", k), 32'(up_if.busy), 32'(exp_busy[k]));
      check($sformatf("rnd oe c%0d", k), 32'(dut.r_oe), 32'(exp_oe[k]));
      if (exp_oe[k]) check($sformatf("rnd DATA c%0d", k), 32'(data_bus), 32'(exp_wdata[k]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ft_async_sched.md
# ft_async_sched

Sequencer and arbiter for the FT2232H asynchronous 245-FIFO bus. It shares the single bidirectional `DATA` bus between two directions: host-to-FPGA reads (when `RXF_N` is low) and FPGA-to-host writes (when `TXE_N` is low and data is queued). It generates `RD_N`/`WR_N` strobes with programmable cycle timing and never drives `DATA` while a read is active. It sits between the FT2232H pins and the uP-side `ext_*` streaming interface.

## Interface
- `DATA`, default 8: bus width.
- `RD_SAMPLE_CYC`, default 3: cycles from `RD_N` falling to data capture (15 ns at 200 MHz).
- `RD_PULSE_CYC`, default 6: `RD_N` low width in cycles.
- `WR_SETUP_CYC`, default 1: `DATA` driven before `WR_N` falls.
- `WR_PULSE_CYC`, default 6: `WR_N` low width.
- `RECOV_CYC`, default 6: strobe-high recovery before next arbitration.

Ports:
- `clk` in 1: single clock, 200 MHz nominal.
- `rst` in 1: synchronous, active-high reset.
- `ext_wr` in 1: write request; data on `ext_wr_data` is valid.
- `ext_wr_data` in DATA: byte to send to the host.
- `ext_wr_ack` out 1: one-cycle pulse; `ext_wr_data` consumed this cycle.
- `ext_rd` in 1: uP can accept a read byte (back-pressure).
- `ext_rd_data_valid` out 1: one-cycle pulse.
- `ext_rd_data` out DATA: captured byte, held until the next capture.
- `busy` out 1: state is not IDLE.
- `RXF_N` in 1, `TXE_N` in 1: FT2232H status, asynchronous.
- `RD_N` out 1, `WR_N` out 1: FT2232H strobes.
- `DATA` inout DATA: tri-stated unless the internal `oe` is 1.

## Operation
- `RXF_N` and `TXE_N` pass through a 2-flop synchronizer; both flops reset to 1.
- The states are IDLE, RD_STROBE, RD_RECOV, WR_SETUP, WR_STROBE, WR_HOLD and WR_RECOV. A single down-counter is loaded on each state entry.
- Request conditions are evaluated only in IDLE:
  - `rd_req` = !rxf_s & `ext_rd`.
  - `wr_req` = !txe_s & `ext_wr`.
- Arbitration:
  - Single request: grant it.
  - Both requests: round-robin using the `last_wr` flag. Grant read if `last_wr`=1, else grant write.
  - `last_wr` resets to 1, so the first tie goes to read.
- Read grant:
  - RD_STROBE: `RD_N`=0 for RD_PULSE_CYC cycles.
  - On the RD_SAMPLE_CYC-th edge, `DATA` is captured into `ext_rd_data`, and `ext_rd_data_valid`=1 on the following cycle only.
  - RD_RECOV: `RD_N`=1 for RECOV_CYC cycles, then IDLE.
- Write grant:
  - In the IDLE cycle of the grant: `ext_wr_ack`=1 and `ext_wr_data` is latched into the holding register.
  - WR_SETUP: `oe`=1, `WR_N`=1 for WR_SETUP_CYC cycles.
  - WR_STROBE: `WR_N`=0 for WR_PULSE_CYC cycles.
  - WR_HOLD: `WR_N`=1, `oe`=1 for 1 cycle.
  - WR_RECOV: `oe`=0 for RECOV_CYC cycles, then IDLE.
- Invariants:
  - `RD_N`=0 and `oe`=1 are never both true.
  - `RD_N` and `WR_N` are never both 0.
  - `oe` is 0 in IDLE.
- `RXF_N`/`TXE_N` changes after a grant are ignored until the next IDLE.
- `ext_rd` deasserting mid-read does not abort the read; the byte is still delivered.

## Timing
- Reset values: `RD_N`=1, `WR_N`=1, `oe`=0, `ext_rd_data_valid`=0, `ext_rd_data`=0, `ext_wr_ack`=0, `busy`=0, state IDLE.
- Reset mid-transfer: all outputs take their reset values at the reset edge. No partial strobe completes.
- Latencies:
  - `RXF_N` falling to `RD_N` falling: 3 cycles (2 sync + 1 grant).
  - `ext_wr` high (with `TXE_N` low and settled) to `ext_wr_ack`: 1 cycle.
- Minimum transaction periods:
  - Read: RD_PULSE_CYC + RECOV_CYC + 1 = 13 cycles.
  - Write: WR_SETUP_CYC + WR_PULSE_CYC + 1 + RECOV_CYC + 1 = 15 cycles.
- Counter width: $clog2(max cycle param)+1.
- Elaboration fails on either of these:
  - Any cycle parameter is 0.
  - RD_SAMPLE_CYC > RD_PULSE_CYC.

## Structure
- `ft_async_pkg`:
  - State enum.
  - Default cycle constants.
  - `ns2cyc(freq_mhz, ns)` function (ceiling).
- Sub-module `ft_sync2`: 2-flop synchronizer with reset value 1, instantiated twice.

## Test plan
- **Read:** `RXF_N` low, `ext_rd`=1, bus=8'hA5.
  - `RD_N` falls 3 cycles later and stays low 6 cycles.
  - `ext_rd_data`=8'hA5 with a single-cycle valid pulse.
- **Write:** `TXE_N` low, `ext_wr`=1, data=8'h3C.
  - 1-cycle `ext_wr_ack`.
  - `DATA`=8'h3C is driven 1 cycle before `WR_N` falls, `WR_N` is low 6 cycles, and `DATA` is held 1 cycle after `WR_N` rises.
- **Tie:** both `RXF_N` and `TXE_N` low, `ext_rd` and `ext_wr` held high.
  - Grants alternate R, W, R, W.
  - The `RD_N`/`oe` overlap checker never fires.
- **Back-pressure:** `RXF_N` low, `ext_rd`=0 for 20 cycles.
  - `RD_N` stays 1.
  - Raising `ext_rd` makes `RD_N` fall 1 cycle later.
- **Reset during WR_STROBE:** `WR_N`=1 and `oe`=0 at the reset edge; `busy`=0.
- **Glitch:** `RXF_N` rises during RD_STROBE.
  - The strobe still completes the full 6 cycles.
  - No new read is started.
